// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_MAX_BURST    = 16;
  localparam int unsigned DEF_IDLE_TIMEOUT = 8;

  // Width of a counter that must hold 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester and FIFO-side signals of the shared write port, plus status/config.
interface fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_enable;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_en;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic [NUM_REQ-1:0]            burst_truncated;
  logic [NUM_REQ-1:0]            grant_timeout;
  logic                          clear_flags;

  modport master (
    input  req_enable, req_valid, req_data, req_last, fifo_full, clear_flags,
    output req_ready, fifo_wr_data, fifo_wr_en, grant, busy,
           burst_truncated, grant_timeout
  );

  modport slave (
    output req_enable, req_valid, req_data, req_last, fifo_full, clear_flags,
    input  req_ready, fifo_wr_data, fifo_wr_en, grant, busy,
           burst_truncated, grant_timeout
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible index after rr_ptr, wrapping.
module rr_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);
  int unsigned  cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(rr_ptr) + off) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locked sharing of one FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input logic                 aclk,
  input logic                 reset,
  fifo_write_arbiter_if.master bus
);
  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned BW = cnt_width(MAX_BURST);
  localparam int unsigned TW = cnt_width(IDLE_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      grant_idx_q, grant_idx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] trunc_q, trunc_d;
  logic [NUM_REQ-1:0] tmo_q, tmo_d;

  logic [IW-1:0] sel_idx;
  logic          sel_found;
  logic          cur_valid;
  logic          beat;
  logic          rel;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_select (
    .eligible (bus.req_valid & bus.req_enable),
    .rr_ptr   (rr_ptr_q),
    .idx      (sel_idx),
    .found    (sel_found)
  );

  // The port is gated during reset so a grant being aborted never writes.
  assign cur_valid = bus.req_valid[grant_idx_q];
  assign beat      = (state_q == LOCKED) && cur_valid && !bus.fifo_full && !reset;

  assign bus.fifo_wr_en      = beat;
  assign bus.req_ready       = beat ? (NUM_REQ'(1) << grant_idx_q) : '0;
  assign bus.fifo_wr_data    = bus.req_data[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant           = grant_q;
  assign bus.busy            = busy_q;
  assign bus.burst_truncated = trunc_q;
  assign bus.grant_timeout   = tmo_q;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    grant_d     = grant_q;
    rel         = 1'b0;
    // Clear first so a same-cycle set below wins.
    trunc_d     = bus.clear_flags ? '0 : trunc_q;
    tmo_d       = bus.clear_flags ? '0 : tmo_q;

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d     = LOCKED;
          grant_idx_d = sel_idx;
          grant_d     = NUM_REQ'(1) << sel_idx;
          beat_cnt_d  = '0;
          idle_cnt_d  = '0;
        end
      end
      LOCKED: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          idle_cnt_d = '0;
          if (bus.req_last[grant_idx_q]) begin
            rel = 1'b1;
          end else if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            rel                  = 1'b1;
            trunc_d[grant_idx_q] = 1'b1;
          end
        end else if (!cur_valid) begin
          if (idle_cnt_q == TW'(IDLE_TIMEOUT - 1)) begin
            rel                = 1'b1;
            tmo_d[grant_idx_q] = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
        if (rel) begin
          state_d    = IDLE;
          rr_ptr_d   = grant_idx_q;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          grant_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOCKED);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= IW'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      trunc_q     <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      trunc_q     <= trunc_d;
      tmo_q       <= tmo_d;
    end
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one FIFO write port (data/wr_en/full) between NUM_REQ producers, e.g. AXI FIFO bridges and local sequencers feeding the same command FIFO.
- Arbitration is round-robin, with packet lock: once granted, a requester keeps the port until it presents last, reaches MAX_BURST beats, or stalls past IDLE_TIMEOUT.
- Never writes a full FIFO. Reports per-requester truncation/timeout events as sticky flags.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, FIFO word width.
- MAX_BURST, 16, maximum beats per grant (power of 2 not required, >=1).
- IDLE_TIMEOUT, 8, cycles a locked requester may hold the port with req_valid low before forced release (>=1).

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_enable  in  NUM_REQ  per-requester arbitration enable (software config).
- req_valid  in  NUM_REQ  requester i has a word.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  word is last of requester i's packet.
- req_ready  out  NUM_REQ  word of requester i accepted this cycle.
- fifo_wr_data  out  DATA_WIDTH  data to FIFO.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full.
- grant  out  NUM_REQ  one-hot current owner (0 when idle).
- busy  out  1  port locked.
- burst_truncated  out  NUM_REQ  sticky: grant ended by MAX_BURST without last.
- grant_timeout  out  NUM_REQ  sticky: grant ended by IDLE_TIMEOUT.
- clear_flags  in  1  one-cycle pulse clearing both sticky vectors.

Behaviour:
- Eligible(i) = req_valid[i] && req_enable[i].
- States: IDLE, LOCKED.
- IDLE:
  - If any requester is eligible, select the first eligible index searching from rr_ptr+1 upward, modulo NUM_REQ.
  - Register it as grant_idx and move to LOCKED. Arbitration latency is 1 cycle; no transfer occurs in IDLE.
- LOCKED:
  - beat = req_valid[grant_idx] && !fifo_full.
  - fifo_wr_en = beat; req_ready[grant_idx] = beat. All other req_ready are 0.
  - fifo_wr_data = req_data of grant_idx. It is combinational and may be undefined-but-stable when fifo_wr_en=0.
  - req_enable[grant_idx] dropping mid-grant does not end the grant.
  - beat_cnt increments on each beat.
  - Release (to IDLE next cycle, rr_ptr <= grant_idx, beat_cnt <= 0, grant <= 0) on the first of:
    - beat && req_last → normal release.
    - beat && beat_cnt == MAX_BURST-1 && !req_last → set burst_truncated[grant_idx].
    - idle_cnt == IDLE_TIMEOUT-1 with req_valid low → set grant_timeout[grant_idx].
  - idle_cnt increments on cycles with req_valid[grant_idx]=0. It resets to 0 on any cycle with req_valid=1.
  - A fifo_full stall with valid=1 is not idle and never times out.
- Sticky flags:
  - Set has priority over clear_flags in the same cycle.
  - Flags hold until clear_flags or reset.
- Reset values:
  - state=IDLE; grant=0; busy=0; req_ready=0; fifo_wr_en=0.
  - Both flag vectors 0; beat_cnt=idle_cnt=0.
  - rr_ptr=NUM_REQ-1, so index 0 wins first.
- Reset mid-burst aborts the grant immediately. No write is issued in the reset cycle.
- Counter widths are $clog2(MAX_BURST+1) and $clog2(IDLE_TIMEOUT+1). There is no wrap-around, because release occurs at the limit.
- busy = (state==LOCKED).
- fifo_wr_en is never asserted while fifo_full=1.

Decomposition:
- Shared package fifo_arb_pkg holds the state enum (IDLE, LOCKED) and the clog2-width helper constants.
- One sub-module, rr_select: combinational round-robin priority picker. Inputs: eligible vector, rr_ptr. Outputs: index, found.

Test Plan:
- Req0 and Req2 valid from the cycle reset deasserts, each sending 3 words with last on the 3rd, fifo_full=0 → grant=0001 for 3 beats, 1 idle cycle, grant=0100 for 3 beats; FIFO receives 6 words in order.
- All 4 requesters continuously valid, 1-word packets → grants cycle 0,1,2,3,0; each beat separated by 1 arbitration cycle.
- Req1 sends 20 words, never asserting last, MAX_BURST=16 → release after 16 beats, burst_truncated=0010; req1 regranted after other requesters are served; clear_flags → 0000.
- Req3 granted, sends 2 words, then drops valid for 8 cycles → forced release on the 8th idle cycle, grant_timeout=1000, next eligible requester granted.
- fifo_full held high for 5 cycles mid-burst with valid high → fifo_wr_en=0 and req_ready=0 for 5 cycles, no timeout, burst resumes with no data lost or duplicated.
- Reset asserted mid-burst at beat 4 → next cycle: grant=0, busy=0, flags=0; after release, requester 0 is the first to win.
